matr_ram_param: RTL



---
 rtl/matr_ram_param.sv | 111 +++++++++++
 1 files changed

// File: rtl/matr_ram_param.sv
// Single-clock matrix buffer with one read and one write port, a built-in clear
// sweep after reset or on request, and a sticky illegal-access flag.
//
// state | meaning
// ------+----------------------------------------------------------------
// CLEAR | sweep writes INIT_VAL to every entry; user accesses rejected
// READY | normal read/write service with address range checking
module matr_ram_param #(
   parameter int WIDTH = 13,
   parameter int DEPTH = 32,
   parameter int AW = 5,
   parameter int BYPASS = 1,
   parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             matr_rd,
   input  logic [AW-1:0]    matr_rd_addr,
   output logic [WIDTH-1:0] matr_dataout,
   output logic             matr_rd_vld,
   input  logic             matr_wr,
   input  logic [AW-1:0]    matr_wr_addr,
   input  logic [WIDTH-1:0] matr_datain,
   output logic             init_busy,
   output logic             addr_err
);

   localparam logic [0:0] CLEAR = 1'b0;
   localparam logic [0:0] READY = 1'b1;

   logic [0:0]       state;
   logic [AW-1:0]    cnt;
   logic [WIDTH-1:0] mem [DEPTH];

   logic             rd_in_range;
   logic             wr_in_range;
   logic             accept;
   logic             wr_ok;
   logic             mem_we;
   logic [AW-1:0]    mem_addr;
   logic [WIDTH-1:0] mem_din;
   logic [WIDTH-1:0] rd_data;

   always_comb begin
      rd_in_range = 32'(matr_rd_addr) < 32'(DEPTH);
      wr_in_range = 32'(matr_wr_addr) < 32'(DEPTH);
      accept      = (state == READY) && !clr;
      wr_ok       = accept && matr_wr && wr_in_range;
      mem_we      = !reset && (((state == CLEAR) && !clr) || wr_ok);
      mem_addr    = (state == CLEAR) ? cnt : matr_wr_addr;
      mem_din     = (state == CLEAR) ? INIT_VAL : matr_datain;
      // Same-address collision: forward the incoming word or keep the array's old value.
      if ((BYPASS != 0) && matr_wr && (matr_wr_addr == matr_rd_addr))
         rd_data = matr_datain;
      else
         rd_data = mem[matr_rd_addr];
   end

   always_ff @(posedge clk) begin
      if (mem_we)
         mem[mem_addr] <= mem_din;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= CLEAR;
         cnt          <= '0;
         matr_dataout <= '0;
         matr_rd_vld  <= 1'b0;
         addr_err     <= 1'b0;
      end else begin
         case (state)
            CLEAR: begin
               matr_rd_vld <= 1'b0;
               if (matr_rd || matr_wr)
                  addr_err <= 1'b1;
               if (clr) begin
                  cnt <= '0;
               end else if (cnt == AW'(DEPTH - 1)) begin
                  state <= READY;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            READY: begin
               if (clr) begin
                  state       <= CLEAR;
                  cnt         <= '0;
                  addr_err    <= 1'b0;
                  matr_rd_vld <= 1'b0;
               end else begin
                  matr_rd_vld <= matr_rd;
                  if (matr_rd)
                     matr_dataout <= rd_in_range ? rd_data : '0;
                  if ((matr_rd && !rd_in_range) || (matr_wr && !wr_in_range))
                     addr_err <= 1'b1;
               end
            end
            default: begin
               state <= CLEAR;
               cnt   <= '0;
            end
         endcase
      end
   end

   assign init_busy = (state == CLEAR);

endmodule
